// File: rtl/boot_rom_pkg.sv
// boot_rom_window shared definitions: unlock key, unmap states, window offsets.
package boot_rom_pkg;

    localparam logic [7:0] UNMAP_KEY = 8'hA5;

    typedef enum logic [1:0] {
        ST_MAPPED   = 2'd0,
        ST_PENDING  = 2'd1,
        ST_UNMAPPED = 2'd2
    } unmap_state_e;

    function automatic int unsigned scratch_off(
        input int unsigned win_aw,
        input int unsigned n_scratch
    );
        return (32'd1 << win_aw) - n_scratch;
    endfunction

    function automatic int unsigned ctrl_off(
        input int unsigned win_aw,
        input int unsigned n_scratch
    );
        return scratch_off(win_aw, n_scratch) - 32'd1;
    endfunction

endpackage

// File: rtl/boot_rom_image.sv
// Boot image lookup, assembled from the boot listing with board values patched in.
module boot_rom_image #(
    parameter int ROM_AW = 8
) (
    input  logic [ROM_AW-1:0] rom_ptr,
    input  logic [15:0]       ram_start,
    input  logic [15:0]       ram_end,
    input  logic [7:0]        cs_port_bit,
    output logic [7:0]        rom_data
);

    // ld sp,ram_end / ld hl,ram_start / ld a,cs / out (40h),a / clear loop / halt
    always_comb begin
        rom_data = 8'h00;
        case (int'(rom_ptr))
            0:  rom_data = 8'h31;
            1:  rom_data = ram_end[7:0];
            2:  rom_data = ram_end[15:8];
            3:  rom_data = 8'h21;
            4:  rom_data = ram_start[7:0];
            5:  rom_data = ram_start[15:8];
            6:  rom_data = 8'h3E;
            7:  rom_data = cs_port_bit;
            8:  rom_data = 8'hD3;
            9:  rom_data = 8'h40;
            10: rom_data = 8'h36;
            11: rom_data = 8'hAA;
            12: rom_data = 8'h23;
            13: rom_data = 8'h18;
            14: rom_data = 8'hFB;
            15: rom_data = 8'h76;
            default: rom_data = 8'h00;
        endcase
    end

endmodule

// File: rtl/boot_rom_window.sv
// Boot ROM window: snoops the muxed CPU bus, serves image/scratch/CTRL
// and unmaps itself after a keyed CTRL write followed by an le_hi_act.
module boot_rom_window
    import boot_rom_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter logic [15:0] ROM_BASE  = 16'h0000,
    parameter int          WIN_AW    = 13,
    parameter int          ROM_AW    = 8,
    parameter int          N_SCRATCH = 2
) (
    input  logic        wb_clk_i,
    input  logic        rstb,
    input  logic        WEb_raw,
    input  logic        le_lo_act,
    input  logic        le_hi_act,
    input  logic [7:0]  bus_in,
    output logic [7:0]  bus_out,
    output logic        rom_sel,
    output logic        rom_mapped,
    input  logic        rom_enabled,
    input  logic [15:0] ram_start,
    input  logic [15:0] ram_end,
    input  logic [2:0]  cs_port
);

    localparam logic [WIN_AW-1:0] SCR_OFF  =
        WIN_AW'(scratch_off(WIN_AW, N_SCRATCH));
    localparam logic [WIN_AW-1:0] CTRL_OFF =
        WIN_AW'(ctrl_off(WIN_AW, N_SCRATCH));

    logic [ADDR_W-1:0]    r_addr;
    logic                 r_we_q;
    logic [7:0]           r_scratch [N_SCRATCH];
    unmap_state_e         r_state;

    logic [WIN_AW-1:0]    w_off;
    logic                 w_hit;
    logic                 w_is_img;
    logic                 w_is_ctrl;
    logic                 w_commit;
    logic                 w_wr;
    logic                 w_ctrl_wr;
    logic [N_SCRATCH-1:0] w_scr_hit;
    logic [7:0]           w_cs_bit;
    logic [7:0]           w_img;
    logic [7:0]           w_rd;

    // Base is window-aligned, so the low bits alone give the in-window offset.
    assign w_off      = r_addr[WIN_AW-1:0] - ROM_BASE[WIN_AW-1:0];
    assign w_hit      = r_addr[ADDR_W-1:WIN_AW] == ROM_BASE[ADDR_W-1:WIN_AW];
    assign w_is_img   = ~|w_off[WIN_AW-1:ROM_AW];
    assign w_is_ctrl  = (w_off == CTRL_OFF) & ~w_is_img;
    assign w_cs_bit   = 8'b1 << cs_port;

    assign rom_mapped = r_state != ST_UNMAPPED;
    assign rom_sel    = rom_enabled & w_hit & rom_mapped;
    assign w_commit   = ~WEb_raw & r_we_q;
    assign w_wr       = w_commit & rom_sel;
    assign w_ctrl_wr  = w_wr & w_is_ctrl;

    boot_rom_image #(
        .ROM_AW(ROM_AW)
    ) u_image (
        .rom_ptr    (w_off[ROM_AW-1:0]),
        .ram_start  (ram_start),
        .ram_end    (ram_end),
        .cs_port_bit(w_cs_bit),
        .rom_data   (w_img)
    );

    always_comb begin
        w_scr_hit = '0;
        for (int k = 0; k < N_SCRATCH; k++) begin
            w_scr_hit[k] = ~w_is_img & (w_off == SCR_OFF + WIN_AW'(k));
        end
    end

    always_comb begin
        w_rd = 8'h00;
        if (w_is_img) begin
            w_rd = w_img;
        end else if (w_is_ctrl) begin
            w_rd = {7'b0, rom_mapped};
        end else begin
            for (int k = 0; k < N_SCRATCH; k++) begin
                if (w_scr_hit[k]) w_rd = r_scratch[k];
            end
        end
    end

    assign bus_out = w_hit ? w_rd : 8'h00;

    always_ff @(posedge wb_clk_i or negedge rstb) begin
        if (!rstb) begin
            r_addr <= '0;
            r_we_q <= 1'b1;
        end else begin
            r_we_q <= WEb_raw;
            if (!rom_enabled) begin
                r_addr <= '0;
            end else begin
                if (le_lo_act) r_addr[7:0] <= bus_in;
                if (le_hi_act) r_addr[ADDR_W-1:8] <= bus_in[ADDR_W-9:0];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge rstb) begin
        if (!rstb) begin
            for (int k = 0; k < N_SCRATCH; k++) r_scratch[k] <= 8'h00;
        end else begin
            for (int k = 0; k < N_SCRATCH; k++) begin
                if (w_wr && w_scr_hit[k]) r_scratch[k] <= bus_in;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge rstb) begin
        if (!rstb) begin
            r_state <= ST_MAPPED;
        end else begin
            unique case (r_state)
                ST_MAPPED: begin
                    if (w_ctrl_wr && bus_in == UNMAP_KEY) r_state <= ST_PENDING;
                end
                ST_PENDING: begin
                    if (le_hi_act) begin
                        r_state <= ST_UNMAPPED;
                    end else if (w_ctrl_wr && bus_in != UNMAP_KEY) begin
                        r_state <= ST_MAPPED;
                    end
                end
                ST_UNMAPPED: r_state <= ST_UNMAPPED;
                default:     r_state <= ST_MAPPED;
            endcase
        end
    end

endmodule
